// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V types, CSR addresses and interrupt constants
package riscv_pkg;

   localparam int RV_XLEN = 32;

   typedef enum logic [1:0] {
      PRIV_U = 2'b00,
      PRIV_S = 2'b01,
      PRIV_M = 2'b11
   } priv_t;

   typedef logic [11:0]        csr_t;
   typedef logic [RV_XLEN-1:0] ex_cause_t;

   localparam csr_t CSR_MIP     = 12'h344;
   localparam csr_t CSR_MIE     = 12'h304;
   localparam csr_t CSR_MIDELEG = 12'h303;
   localparam csr_t CSR_SIP     = 12'h144;
   localparam csr_t CSR_SIE     = 12'h104;

   localparam int IRQ_SSI       = 1;
   localparam int IRQ_MSI       = 3;
   localparam int IRQ_STI       = 5;
   localparam int IRQ_MTI       = 7;
   localparam int IRQ_SEI       = 9;
   localparam int IRQ_MEI       = 11;
   localparam int IRQ_PLAT_BASE = 16;

   localparam logic [63:0] MIE_STD_MASK = 64'h0000_0AAA;
   localparam logic [63:0] MIDELEG_MASK = 64'h0000_0222;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      WAIT = 2'b10
   } intr_state_t;

   // Platform enables sit contiguously above the standard set.
   function automatic logic [63:0] mie_wmask(input int unsigned nr_plat);
      return MIE_STD_MASK | (((64'd1 << nr_plat) - 64'd1) << IRQ_PLAT_BASE);
   endfunction

endpackage

// File: rtl/riscv_intr_ctrl_if.sv
// rtl/riscv_intr_ctrl_if.sv - CSR access and trap handshake between core and interrupt controller
interface riscv_intr_ctrl_if
   import riscv_pkg::*;
#(
   parameter int XLEN = RV_XLEN
);
   logic            csr_we_i;
   csr_t            csr_addr_i;
   logic [XLEN-1:0] csr_wdata_i;
   logic [XLEN-1:0] csr_rdata_o;
   logic            csr_hit_o;
   logic            intr_req_o;
   logic [XLEN-1:0] intr_cause_o;
   logic            intr_to_s_o;
   logic            intr_ack_i;

   modport master (
      output csr_we_i, csr_addr_i, csr_wdata_i, intr_ack_i,
      input  csr_rdata_o, csr_hit_o, intr_req_o, intr_cause_o, intr_to_s_o
   );

   modport slave (
      input  csr_we_i, csr_addr_i, csr_wdata_i, intr_ack_i,
      output csr_rdata_o, csr_hit_o, intr_req_o, intr_cause_o, intr_to_s_o
   );
endinterface

// File: rtl/riscv_sync.sv
// rtl/riscv_sync.sv - N-stage W-bit synchroniser with asynchronous active-low reset
module riscv_sync #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] stage_q [N];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[N-1];
endmodule

// File: rtl/riscv_intr_ctrl.sv
// rtl/riscv_intr_ctrl.sv - mip/mie/mideleg owner and M/S interrupt arbitration for one hart
module riscv_intr_ctrl
   import riscv_pkg::*;
#(
   parameter int XLEN        = RV_XLEN,
   parameter int NR_PLAT     = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               irq_m_ext_i,
   input  logic               irq_m_timer_i,
   input  logic               irq_m_sw_i,
   input  logic               irq_s_ext_i,
   input  logic [NR_PLAT-1:0] irq_plat_i,
   input  priv_t              priv_i,
   input  logic               mstatus_mie_i,
   input  logic               mstatus_sie_i,
   output logic               wfi_wake_o,
   riscv_intr_ctrl_if.slave   bus
);
   localparam int W = 4 + NR_PLAT;
   localparam logic [XLEN-1:0] MIE_MASK = XLEN'(mie_wmask(NR_PLAT));
   localparam logic [XLEN-1:0] DLG_MASK = XLEN'(MIDELEG_MASK);

   logic [W-1:0]       sync_q;
   logic               meip_s, mtip_s, msip_s, seip_s;
   logic [NR_PLAT-1:0] plat_s;

   riscv_sync #(.N(SYNC_STAGES), .W(W)) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    ({irq_plat_i, irq_s_ext_i, irq_m_sw_i, irq_m_timer_i, irq_m_ext_i}),
      .q_o    (sync_q)
   );

   assign {plat_s, seip_s, msip_s, mtip_s, meip_s} = sync_q;

   logic            ssip_q, stip_q, seip_sw_q;
   logic [XLEN-1:0] mie_q, mideleg_q, mip;

   always_comb begin
      mip          = '0;
      mip[IRQ_MEI] = meip_s;
      mip[IRQ_MTI] = mtip_s;
      mip[IRQ_MSI] = msip_s;
      mip[IRQ_SEI] = seip_sw_q | seip_s;
      mip[IRQ_STI] = stip_q;
      mip[IRQ_SSI] = ssip_q;
      for (int i = 0; i < NR_PLAT; i++) mip[IRQ_PLAT_BASE+i] = plat_s[i];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ssip_q    <= 1'b0;
         stip_q    <= 1'b0;
         seip_sw_q <= 1'b0;
         mie_q     <= '0;
         mideleg_q <= '0;
      end else if (bus.csr_we_i) begin
         case (bus.csr_addr_i)
            CSR_MIP: begin
               ssip_q    <= bus.csr_wdata_i[IRQ_SSI];
               stip_q    <= bus.csr_wdata_i[IRQ_STI];
               seip_sw_q <= bus.csr_wdata_i[IRQ_SEI];
            end
            CSR_SIP:     if (mideleg_q[IRQ_SSI]) ssip_q <= bus.csr_wdata_i[IRQ_SSI];
            CSR_MIE:     mie_q     <= bus.csr_wdata_i & MIE_MASK;
            // mideleg is a subset of the mie mask, so no extra masking is needed here.
            CSR_SIE:     mie_q     <= (mie_q & ~mideleg_q) | (bus.csr_wdata_i & mideleg_q);
            CSR_MIDELEG: mideleg_q <= bus.csr_wdata_i & DLG_MASK;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.csr_rdata_o = '0;
      bus.csr_hit_o   = 1'b1;
      case (bus.csr_addr_i)
         CSR_MIP:     bus.csr_rdata_o = mip;
         CSR_MIE:     bus.csr_rdata_o = mie_q;
         CSR_MIDELEG: bus.csr_rdata_o = mideleg_q;
         CSR_SIP:     bus.csr_rdata_o = mip & mideleg_q;
         CSR_SIE:     bus.csr_rdata_o = mie_q & mideleg_q;
         default:     bus.csr_hit_o   = 1'b0;
      endcase
   end

   // Later assignments override earlier ones, so tests run lowest priority first.
   function automatic logic [6:0] pick(input logic [XLEN-1:0] p);
      logic [6:0] r;
      r = '0;
      if (p[IRQ_STI]) r = {1'b1, 6'(IRQ_STI)};
      if (p[IRQ_SSI]) r = {1'b1, 6'(IRQ_SSI)};
      if (p[IRQ_SEI]) r = {1'b1, 6'(IRQ_SEI)};
      if (p[IRQ_MTI]) r = {1'b1, 6'(IRQ_MTI)};
      if (p[IRQ_MSI]) r = {1'b1, 6'(IRQ_MSI)};
      if (p[IRQ_MEI]) r = {1'b1, 6'(IRQ_MEI)};
      for (int i = 0; i < NR_PLAT; i++)
         if (p[IRQ_PLAT_BASE+i]) r = {1'b1, 6'(IRQ_PLAT_BASE + i)};
      return r;
   endfunction

   logic [XLEN-1:0] pend;
   logic            m_elig, s_elig, cand, cand_to_s;
   logic [6:0]      m_best, s_best;
   logic [5:0]      cand_idx;

   always_comb begin
      pend      = mip & mie_q;
      m_elig    = (priv_i != PRIV_M) || mstatus_mie_i;
      s_elig    = (priv_i == PRIV_U) || ((priv_i == PRIV_S) && mstatus_sie_i);
      m_best    = m_elig ? pick(pend & ~mideleg_q) : 7'd0;
      s_best    = s_elig ? pick(pend &  mideleg_q) : 7'd0;
      cand      = m_best[6] | s_best[6];
      cand_to_s = !m_best[6];
      cand_idx  = m_best[6] ? m_best[5:0] : s_best[5:0];
   end

   intr_state_t     state_q, state_d;
   logic            load;
   logic [XLEN-1:0] cause_q;
   logic            to_s_q, wake_q;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         IDLE: if (cand) begin
            state_d = REQ;
            load    = 1'b1;
         end
         REQ: begin
            if (bus.intr_ack_i) state_d = WAIT;
            else if (!cand)     state_d = IDLE;
            else                load    = 1'b1;
         end
         WAIT:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cause_q <= '0;
         to_s_q  <= 1'b0;
         wake_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wake_q  <= |pend;
         if (load) begin
            cause_q           <= '0;
            cause_q[XLEN-1]   <= 1'b1;
            cause_q[5:0]      <= cand_idx;
            to_s_q            <= cand_to_s;
         end
      end
   end

   assign bus.intr_req_o   = (state_q == REQ);
   assign bus.intr_cause_o = cause_q;
   assign bus.intr_to_s_o  = to_s_q;
   assign wfi_wake_o       = wake_q;
endmodule

// File: tb/tb_riscv_intr_ctrl.sv
// tb/tb_riscv_intr_ctrl.sv - directed self-checking bench for riscv_intr_ctrl
module tb_riscv_intr_ctrl;
   import riscv_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       m_ext = 1'b0, m_timer = 1'b0, m_sw = 1'b0, s_ext = 1'b0;
   logic [3:0] plat = 4'd0;
   priv_t      priv = PRIV_M;
   logic       st_mie = 1'b0, st_sie = 1'b0;
   logic       wake;
   int         checks = 0;
   int         failures = 0;

   riscv_intr_ctrl_if #(.XLEN(32)) bus ();

   riscv_intr_ctrl #(.XLEN(32), .NR_PLAT(4), .SYNC_STAGES(2)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .irq_m_ext_i   (m_ext),
      .irq_m_timer_i (m_timer),
      .irq_m_sw_i    (m_sw),
      .irq_s_ext_i   (s_ext),
      .irq_plat_i    (plat),
      .priv_i        (priv),
      .mstatus_mie_i (st_mie),
      .mstatus_sie_i (st_sie),
      .wfi_wake_o    (wake),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic csr_wr(input csr_t a, input logic [31:0] d);
      bus.csr_we_i    = 1'b1;
      bus.csr_addr_i  = a;
      bus.csr_wdata_i = d;
      step();
      bus.csr_we_i    = 1'b0;
   endtask

   task automatic csr_chk(input string tag, input csr_t a, input logic [31:0] exp);
      bus.csr_addr_i = a;
      #1;
      chk(tag, bus.csr_rdata_o, exp);
   endtask

   task automatic ack_and_idle(input string tag);
      bus.intr_ack_i = 1'b1;
      {m_ext, m_timer, m_sw, s_ext, plat} = '0;
      step();
      bus.intr_ack_i = 1'b0;
      chk({tag, "_wait"}, 32'(bus.intr_req_o), 32'd0);
      step();
      step();
      chk({tag, "_idle"}, 32'(bus.intr_req_o), 32'd0);
   endtask

   initial begin
      bus.csr_we_i    = 1'b0;
      bus.csr_addr_i  = 12'h000;
      bus.csr_wdata_i = '0;
      bus.intr_ack_i  = 1'b0;

      // Reset state
      step();
      step();
      chk("rst_req", 32'(bus.intr_req_o), 32'd0);
      chk("rst_cause", bus.intr_cause_o, 32'd0);
      chk("rst_to_s", 32'(bus.intr_to_s_o), 32'd0);
      chk("rst_wake", 32'(wake), 32'd0);
      rst_n = 1'b1;
      step();
      csr_chk("rst_mip", CSR_MIP, 32'd0);
      csr_chk("rst_mie", CSR_MIE, 32'd0);
      csr_chk("rst_mideleg", CSR_MIDELEG, 32'd0);
      chk("hit_mie", 32'(bus.csr_hit_o), 32'd0 + 32'(bus.csr_addr_i == CSR_MIDELEG));
      bus.csr_addr_i = 12'h300;
      #1;
      chk("hit_other", 32'(bus.csr_hit_o), 32'd0);
      chk("rdata_other", bus.csr_rdata_o, 32'd0);

      // CSR write masks
      csr_wr(CSR_MIE, 32'hFFFF_FFFF);
      csr_chk("mie_mask", CSR_MIE, 32'h000F_0AAA);
      csr_wr(CSR_MIDELEG, 32'hFFFF_FFFF);
      csr_chk("mideleg_mask", CSR_MIDELEG, 32'h0000_0222);
      csr_wr(CSR_MIDELEG, 32'd0);
      csr_wr(CSR_MIE, 32'd0);
      csr_wr(CSR_SIP, 32'h2);
      csr_chk("sip_undeleg", CSR_MIP, 32'd0);

      // Machine timer in M-mode
      priv   = PRIV_M;
      st_mie = 1'b1;
      csr_wr(CSR_MIE, 32'h80);
      m_timer = 1'b1;
      step();
      step();
      chk("tmr_req_early", 32'(bus.intr_req_o), 32'd0);
      step();
      chk("tmr_req", 32'(bus.intr_req_o), 32'd1);
      chk("tmr_cause", bus.intr_cause_o, 32'h8000_0007);
      chk("tmr_to_s", 32'(bus.intr_to_s_o), 32'd0);
      chk("tmr_wake", 32'(wake), 32'd1);
      ack_and_idle("tmr_ack");

      // Priority MEI over MTI, then reload when MEI drops
      csr_wr(CSR_MIE, 32'h880);
      m_timer = 1'b1;
      m_ext   = 1'b1;
      step();
      step();
      step();
      chk("pri_req", 32'(bus.intr_req_o), 32'd1);
      chk("pri_cause_mei", bus.intr_cause_o, 32'h8000_000B);
      m_ext = 1'b0;
      step();
      step();
      chk("pri_cause_hold", bus.intr_cause_o, 32'h8000_000B);
      step();
      chk("pri_cause_mti", bus.intr_cause_o, 32'h8000_0007);
      chk("pri_req_kept", 32'(bus.intr_req_o), 32'd1);
      ack_and_idle("pri_ack");

      // Delegated supervisor timer
      priv   = PRIV_S;
      st_sie = 1'b1;
      csr_wr(CSR_MIDELEG, 32'h222);
      csr_wr(CSR_MIE, 32'h20);
      csr_wr(CSR_MIP, 32'h20);
      chk("dlg_req_early", 32'(bus.intr_req_o), 32'd0);
      step();
      chk("dlg_req", 32'(bus.intr_req_o), 32'd1);
      chk("dlg_cause", bus.intr_cause_o, 32'h8000_0005);
      chk("dlg_to_s", 32'(bus.intr_to_s_o), 32'd1);
      csr_chk("dlg_sip", CSR_SIP, 32'h20);
      priv = PRIV_M;
      step();
      chk("dlg_m_req", 32'(bus.intr_req_o), 32'd0);
      chk("dlg_m_wake", 32'(wake), 32'd1);
      step();
      chk("dlg_m_req2", 32'(bus.intr_req_o), 32'd0);
      csr_wr(CSR_MIP, 32'd0);
      st_sie = 1'b0;

      // sip/sie views through delegation
      csr_wr(CSR_SIP, 32'h2);
      csr_chk("sip_deleg", CSR_MIP, 32'h2);
      csr_wr(CSR_SIE, 32'hFFFF_FFFF);
      csr_chk("sie_mie", CSR_MIE, 32'h222);
      csr_chk("sie_read", CSR_SIE, 32'h222);
      csr_wr(CSR_MIP, 32'd0);
      csr_wr(CSR_MIDELEG, 32'd0);
      csr_wr(CSR_MIE, 32'd0);

      // Withdraw by clearing mie
      csr_wr(CSR_MIE, 32'h8);
      m_sw = 1'b1;
      step();
      step();
      step();
      chk("wd_req", 32'(bus.intr_req_o), 32'd1);
      chk("wd_cause", bus.intr_cause_o, 32'h8000_0003);
      csr_wr(CSR_MIE, 32'd0);
      chk("wd_req_n1", 32'(bus.intr_req_o), 32'd1);
      step();
      chk("wd_req_n2", 32'(bus.intr_req_o), 32'd0);

      // Ack coincident with a CSR write wins and forces WAIT
      csr_wr(CSR_MIE, 32'h8);
      step();
      chk("co_req", 32'(bus.intr_req_o), 32'd1);
      bus.intr_ack_i = 1'b1;
      csr_wr(CSR_MIE, 32'h888);
      bus.intr_ack_i = 1'b0;
      chk("co_wait", 32'(bus.intr_req_o), 32'd0);
      step();
      chk("co_idle", 32'(bus.intr_req_o), 32'd0);
      step();
      chk("co_rereq", 32'(bus.intr_req_o), 32'd1);
      chk("co_cause", bus.intr_cause_o, 32'h8000_0003);

      // Asynchronous reset while requesting
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_req", 32'(bus.intr_req_o), 32'd0);
      chk("arst_cause", bus.intr_cause_o, 32'd0);
      csr_chk("arst_mie", CSR_MIE, 32'd0);
      step();
      rst_n = 1'b1;
      repeat (4) step();
      chk("arst_no_req", 32'(bus.intr_req_o), 32'd0);
      csr_wr(CSR_MIE, 32'h8);
      step();
      chk("arst_rereq", 32'(bus.intr_req_o), 32'd1);
      chk("arst_cause2", bus.intr_cause_o, 32'h8000_0003);
      ack_and_idle("arst_ack");

      // Platform line outranks MEI
      csr_wr(CSR_MIE, 32'h0004_0800);
      plat  = 4'b0100;
      m_ext = 1'b1;
      step();
      step();
      csr_chk("plat_mip", CSR_MIP, 32'h0004_0800);
      step();
      chk("plat_req", 32'(bus.intr_req_o), 32'd1);
      chk("plat_cause", bus.intr_cause_o, 32'h8000_0012);
      ack_and_idle("plat_ack");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/riscv_intr_ctrl.md
# riscv_intr_ctrl

Parametrised core-local interrupt controller for the RISC-V hart: owns the `mip`, `mie` and `mideleg` CSRs (plus the `sip`/`sie` views), synchronises the interrupt lines, and resolves M/S targeting, global enables and priority into one interrupt request with a cause code. It sits between the platform interrupt sources and the trap logic of the commit stage. Its interrupt set is the standard M/S software, timer and external interrupts plus `NR_PLAT` platform interrupts at cause 16 and up.

## Interface
- `XLEN`, default `RV_XLEN`: CSR and cause width.
- `NR_PLAT`, default 4: number of platform interrupts at cause `16+i`. Legal range is 0 to XLEN-16.
- `SYNC_STAGES`, default 2: synchroniser depth on every input line. Minimum 1.
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset. Asynchronous, active-low.
- `irq_m_ext_i`, `irq_m_timer_i`, `irq_m_sw_i`, `irq_s_ext_i`, in, 1 each: level interrupt lines, asynchronous.
- `irq_plat_i`, in, NR_PLAT: platform interrupt levels, asynchronous.
- `priv_i`, in, 2 (`priv_t`): current privilege level.
- `mstatus_mie_i`, `mstatus_sie_i`, in, 1 each: global interrupt enables.
- `csr_we_i`, in, 1: CSR write strobe.
- `csr_addr_i`, in, 12 (`csr_t`): CSR address.
- `csr_wdata_i`, in, XLEN: CSR write data, already resolved from RW/RS/RC by the CSR unit.
- `csr_rdata_o`, out, XLEN: combinational read of the addressed CSR.
- `csr_hit_o`, out, 1: address is owned by this block.
- `intr_req_o`, out, 1: an interrupt is requested.
- `intr_cause_o`, out, XLEN (`ex_cause_t`): cause code. Bit XLEN-1 is 1; the low bits hold the index.
- `intr_to_s_o`, out, 1: the trap targets S-mode.
- `intr_ack_i`, in, 1: the core takes the trap.
- `wfi_wake_o`, out, 1: registered OR of `mip & mie`.

## Operation
- Every line passes through `SYNC_STAGES` flops before it reaches `mip`.
- `mip` bit behaviour:
  - MEIP(11), MTIP(7), MSIP(3) and platform bits `16+i` mirror the synced lines and are read-only.
  - SEIP(9) reads as software bit OR synced `irq_s_ext_i`. Writes change only the software bit.
  - STIP(5) and SSIP(1) are software-writable.
- `mie` is writable on bits 1, 3, 5, 7, 9, 11 and 16..16+NR_PLAT-1. All other bits are hard 0.
- `mideleg` is writable on bits 1, 5, 9 only. M bits and platform bits are never delegated.
- CSR addresses: `mip`=0x344, `mie`=0x304, `mideleg`=0x303.
  - `sip`=0x144 reads `mip & mideleg`. Only SSIP is writable through it, and only when delegated.
  - `sie`=0x104 reads and writes `mie` masked by `mideleg`.
  - Any other address: `csr_hit_o`=0, `rdata`=0, writes ignored.
- Candidate set is `P = mip & mie`.
  - M-target bits: `P & ~mideleg`. Eligible when `priv_i`≠M, or when `priv_i`=M and `mstatus_mie_i`=1.
  - S-target bits: `P & mideleg`. Eligible when `priv_i`=U, or when `priv_i`=S and `mstatus_sie_i`=1. Never eligible when `priv_i`=M.
- Priority:
  - An eligible M-target always beats an eligible S-target.
  - Within a target: platform (highest index first) > MEI > MSI > MTI > SEI > SSI > STI.
- Request FSM:
  - IDLE: a candidate exists → REQ. Latch cause and target.
  - REQ, `intr_ack_i`=1 → WAIT. Ack takes priority over every other event in the same cycle.
  - REQ, no ack, no candidate → IDLE. `intr_req_o` is withdrawn.
  - REQ, no ack, best candidate differs → stay in REQ and reload cause and target.
  - WAIT: → IDLE after exactly one cycle. `intr_req_o`=0 during WAIT, giving the core time to update `priv` and `mstatus`.
- `intr_req_o` = (state == REQ). Cause and target are held constant until the next reload.
- Reset values:
  - All state is 0: sync flops, `mip` software bits, `mie`, `mideleg`.
  - FSM is IDLE.
  - `intr_req_o`=0, `intr_cause_o`=0, `intr_to_s_o`=0, `wfi_wake_o`=0.
- Reset asserted mid-request drops `intr_req_o` asynchronously.

## Timing
- Line edge to `mip` bit: `SYNC_STAGES` cycles.
- `mip` to `intr_req_o`: +1 cycle.
- CSR write takes effect on the next edge. A write in cycle n affects the candidate set in cycle n+1 and `intr_req_o` in n+2.
- `csr_rdata_o` is combinational from the registers. A read in the same cycle as a write returns the old value.
- `wfi_wake_o` is registered: 1 cycle after `P` changes. It ignores global enables and delegation.
- Minimum spacing between two acks: 3 cycles (REQ, WAIT, IDLE→REQ).

## Structure
- Add to `riscv_pkg`:
  - CSR address constants for MIP, MIE, MIDELEG, SIP, SIE.
  - Interrupt bit index constants.
  - Writable masks for MIE and MIDELEG.
  - The `intr_state_t` enum (IDLE, REQ, WAIT).
- Submodule `riscv_sync`: parametrised N-stage synchroniser with width W and asynchronous active-low reset. Instantiate it once over all lines.

## Test plan
- Timer set in M-mode: `priv`=M, `mstatus_mie`=1, `mie[7]`=1, pulse `irq_m_timer_i` high. Expect `intr_req_o` at cycle SYNC_STAGES+1, `intr_cause_o`={1,…,7}, `intr_to_s_o`=0. Ack, then expect `intr_req_o`=0 for ≥2 cycles.
- Priority: MTI and MEI raised in the same cycle → cause 11. Drop MEI before ack → cause reloads to 7 while `intr_req_o` stays 1.
- Delegation: `mideleg`=0x222, `priv`=S, `sie`=1, write `mip` STIP=1 with `mie[5]`=1 → cause 5, `intr_to_s_o`=1. Same setup with `priv`=M → no request; `wfi_wake_o`=1.
- CSR masking: write all-ones to `mie` with NR_PLAT=4 → reads 0xF0AAA. Write all-ones to `mideleg` → reads 0x222. Write 0x2 via `sip` with SSIP undelegated → `mip` is unchanged.
- Withdraw: `intr_req_o`=1, then clear `mie` via CSR with no ack → `intr_req_o`=0 two cycles after the write. Write coincident with `intr_ack_i` → FSM enters WAIT.
- Reset in REQ: assert `rst_ni`=0 asynchronously → `intr_req_o`=0 and CSRs read 0. Lines held high → request reappears SYNC_STAGES+1 cycles after reset release only once enables are rewritten.
